tex_sat_lane_seq: RTL and testbench



---
 rtl/tex_sat_lane_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_tex_sat_lane_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tex_sat_lane_seq.sv
// -----------------------------------------------------------------------------
// tex_sat_lane_seq
//
// Shares one saturation datapath across the NUM_LANES texel lanes of a
// texture request. A whole request is captured in one cycle; each active lane
// is then clamped from a signed IN_W value to an unsigned OUT_W value, one
// lane per cycle in ascending lane order; finally the packed result is
// returned together with the captured mask and tag.
//
// Saturation of one lane x:
//   x negative (MSB set)            -> 0
//   any of x[IN_W-2:OUT_W] set      -> all ones
//   otherwise                       -> x[OUT_W-1:0]
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE (and never while reset is
// asserted). rsp_valid is high only in DONE; once high it stays high, with
// rsp_data/rsp_mask/rsp_tag stable, until the edge where rsp_ready is high.
//
// Optional build macro: TEX_SAT_STATS_EN
//   When defined, adds two free-running wrap-around counters:
//     sat_ovf_count - processed lanes whose result landed on full scale
//                     (all ones), i.e. clamped to the top of the range
//     sat_unf_count - processed lanes clamped to 0 because negative
//   Inactive lanes are never counted; each counter moves at most once per
//   RUN cycle.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-low reset
//   req_valid      request valid
//   req_ready      request accepted when high together with req_valid
//   req_mask       active-lane mask
//   req_data       lane values, lane i at [i*IN_W +: IN_W] (two's complement)
//   req_tag        request tag
//   rsp_valid      response valid
//   rsp_ready      downstream ready
//   rsp_data       saturated lanes, lane i at [i*OUT_W +: OUT_W]
//   rsp_mask       captured req_mask
//   rsp_tag        captured req_tag
//   sat_ovf_count  (TEX_SAT_STATS_EN only) high-clamp lane count
//   sat_unf_count  (TEX_SAT_STATS_EN only) negative-clamp lane count
//   state_dbg      current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module tex_sat_lane_seq #(
  parameter int NUM_LANES = 4,
  parameter int IN_W      = 20,
  parameter int OUT_W     = 8,
  parameter int TAG_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [NUM_LANES-1:0]       req_mask,
  input  logic [NUM_LANES*IN_W-1:0]  req_data,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [NUM_LANES*OUT_W-1:0] rsp_data,
  output logic [NUM_LANES-1:0]       rsp_mask,
  output logic [TAG_W-1:0]           rsp_tag,
`ifdef TEX_SAT_STATS_EN
  output logic [31:0]                sat_ovf_count,
  output logic [31:0]                sat_unf_count,
`endif
  output logic [1:0]                 state_dbg
);

  // Parameter sanity: the overflow-detect field x[IN_W-2:OUT_W] must hold at
  // least one bit, and there must be at least one lane.
  if (OUT_W + 1 >= IN_W) begin : g_bad_width
    $error("tex_sat_lane_seq: OUT_W+1 must be less than IN_W");
  end
  if (NUM_LANES < 1) begin : g_bad_lanes
    $error("tex_sat_lane_seq: NUM_LANES must be at least 1");
  end

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [NUM_LANES-1:0] pending_q;
  logic [NUM_LANES-1:0] low_bit;
  logic [NUM_LANES-1:0] pending_clr;
  logic [IDX_W-1:0]     sel_idx;

  logic [IN_W-1:0]      lane_q [NUM_LANES];
  logic [OUT_W-1:0]     res_q  [NUM_LANES];
  logic [NUM_LANES-1:0] mask_q;
  logic [TAG_W-1:0]     tag_q;

  logic [IN_W-1:0]      cur_lane;
  logic                 is_neg;
  logic                 is_big;
  logic [OUT_W-1:0]     sat_val;
  logic                 accept;
  logic                 lane_step;

  // ---------------------------------------------------------------------------
  // Lane selection: lowest set bit of the pending mask.
  // ---------------------------------------------------------------------------
  // x & -x isolates the lowest set bit; clearing it gives the next pending set.
  assign low_bit     = pending_q & (~pending_q + {{(NUM_LANES-1){1'b0}}, 1'b1});
  assign pending_clr = pending_q & ~low_bit;

  // Descending scan so the last assignment wins with the lowest index.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared saturator.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_lane = lane_q[sel_idx];
    is_neg   = cur_lane[IN_W-1];
    is_big   = |cur_lane[IN_W-2:OUT_W];
    if (is_neg) begin
      sat_val = '0;
    end else if (is_big) begin
      sat_val = '1;
    end else begin
      sat_val = cur_lane[OUT_W-1:0];
    end
  end

  assign accept    = req_valid && req_ready;
  // A lane is consumed on every RUN cycle that still has a pending bit.
  assign lane_step = (state_q == S_RUN) && (pending_q != '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // An empty mask has nothing to process, so the response is ready
          // on the very next cycle.
          state_d = (req_mask != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (pending_clr == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // Gated by reset so no request can appear accepted on a reset edge.
    req_ready = (state_q == S_IDLE) && reset;
    rsp_valid = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // ---------------------------------------------------------------------------
  // Request capture and per-lane result register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      tag_q     <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else if (accept) begin
      pending_q <= req_mask;
      mask_q    <= req_mask;
      tag_q     <= req_tag;
      // Result starts at zero so inactive lanes read back as 0.
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= req_data[i*IN_W +: IN_W];
        res_q[i]  <= '0;
      end
    end else if (lane_step) begin
      res_q[sel_idx] <= sat_val;
      pending_q      <= pending_clr;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
    assign rsp_data[g*OUT_W +: OUT_W] = res_q[g];
  end

  assign rsp_mask = mask_q;
  assign rsp_tag  = tag_q;

`ifdef TEX_SAT_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturation statistics. Only lanes actually processed in RUN are counted,
  // so masked-off lanes never contribute. Counters wrap naturally at 2^32.
  // ---------------------------------------------------------------------------
  logic [31:0] ovf_q;
  logic [31:0] unf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else if (lane_step) begin
      if (!is_neg && (sat_val == {OUT_W{1'b1}})) begin
        ovf_q <= ovf_q + 32'd1;
      end
      if (is_neg) begin
        unf_q <= unf_q + 32'd1;
      end
    end
  end

  assign sat_ovf_count = ovf_q;
  assign sat_unf_count = unf_q;
`endif

endmodule

// File: tb/tb_tex_sat_lane_seq.sv
// -----------------------------------------------------------------------------
// tb_tex_sat_lane_seq
//
// Bench for tex_sat_lane_seq at default parameters (4 lanes, IN_W=20, OUT_W=8,
// TAG_W=8). Inputs are driven and outputs sampled on the falling clock edge.
// Expected responses are queued in exp_q when a request is accepted and
// popped when rsp_valid is seen. Build with TEX_SAT_STATS_EN to include the
// counter ports.
// -----------------------------------------------------------------------------
module tb_tex_sat_lane_seq;

  localparam int NL = 4;
  localparam int IW = 20;
  localparam int OW = 8;
  localparam int TW = 8;
  localparam int EW = TW + NL + NL*OW;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [NL-1:0]    req_mask;
  logic [NL*IW-1:0] req_data;
  logic [TW-1:0]    req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [NL*OW-1:0] rsp_data;
  logic [NL-1:0]    rsp_mask;
  logic [TW-1:0]    rsp_tag;
  logic [1:0]       state_dbg;
`ifdef TEX_SAT_STATS_EN
  logic [31:0]      sat_ovf_count;
  logic [31:0]      sat_unf_count;
`endif

  always #5 clk = ~clk;

  tex_sat_lane_seq #(
    .NUM_LANES(NL), .IN_W(IW), .OUT_W(OW), .TAG_W(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_mask(req_mask),
    .req_data(req_data),
    .req_tag(req_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_mask(rsp_mask),
    .rsp_tag(rsp_tag),
`ifdef TEX_SAT_STATS_EN
    .sat_ovf_count(sat_ovf_count),
    .sat_unf_count(sat_unf_count),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  logic [31:0] model_ovf = 0;
  logic [31:0] model_unf = 0;
  logic [IW-1:0] edge_v [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signed-integer view of the clamp: below zero -> 0, above max -> max.
  function automatic logic [OW-1:0] sat_ref(input logic [IW-1:0] x);
    int v;
    int vmax;
    v    = int'($signed(x));
    vmax = (1 << OW) - 1;
    if (v < 0)    return '0;
    if (v > vmax) return OW'(vmax);
    return OW'(v);
  endfunction

  function automatic logic [NL*OW-1:0] model_data(input logic [NL-1:0] m,
                                                  input logic [NL*IW-1:0] d);
    logic [NL*OW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++)
      if (m[i]) r[i*OW +: OW] = sat_ref(d[i*IW +: IW]);
    return r;
  endfunction

  task automatic model_count(input logic [NL-1:0] m, input logic [NL*IW-1:0] d);
    for (int i = 0; i < NL; i++) begin
      if (m[i]) begin
        if (int'($signed(d[i*IW +: IW])) < 0) model_unf = model_unf + 32'd1;
        else if (sat_ref(d[i*IW +: IW]) == {OW{1'b1}}) model_ovf = model_ovf + 32'd1;
      end
    end
  endtask

  function automatic logic [IW-1:0] rand_lane();
    case ($urandom_range(0, 4))
      0:       return IW'($urandom_range(0, 255));
      1:       return {1'b1, (IW-1)'($urandom)};
      2:       return {1'b0, (IW-1)'($urandom)};
      3:       return edge_v[$urandom_range(0, 5)];
      default: return IW'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [NL-1:0] m, input logic [NL*IW-1:0] d,
                      input logic [TW-1:0] t, input logic [NL*OW-1:0] exp_d,
                      input bit keep);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_mask  = m;
    req_data  = d;
    req_tag   = t;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_accept_ready", 64'(req_ready), 64'd1);
    exp_q.push_back({t, m, exp_d});
    model_count(m, d);
    @(negedge clk);  // the rising edge in between is the accept edge
    if (!keep) begin
      // Scramble inputs: post-accept changes must not reach the result.
      req_valid = 1'b0;
      req_mask  = NL'($urandom);
      req_data  = (NL*IW)'({$urandom, $urandom, $urandom});
      req_tag   = TW'($urandom);
    end
  endtask

  // Entered at the falling edge of cycle C+1.
  task automatic wait_rsp(input int exp_lat);
    int n;
    n = 1;
    while (!rsp_valid && n < 40) begin
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    chk("rsp_latency", 64'(n), 64'(exp_lat));
    chk("req_ready_done", 64'(req_ready), 64'd0);
    if (exp_q.size() > 0) last_exp = exp_q.pop_front();
    else last_exp = '0;
    chk("rsp_payload", 64'({rsp_tag, rsp_mask, rsp_data}), 64'(last_exp));
`ifdef TEX_SAT_STATS_EN
    chk("sat_ovf_count", 64'(sat_ovf_count), 64'(model_ovf));
    chk("sat_unf_count", 64'(sat_unf_count), 64'(model_unf));
`endif
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_ack", 64'(rsp_valid), 64'd0);
    chk("req_ready_after_ack", 64'(req_ready), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [NL-1:0]    mask;
    logic [NL*IW-1:0] data;   // {lane3, lane2, lane1, lane0}
    logic [TW-1:0]    tag;
    logic [NL*OW-1:0] exp_data;
    int               exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int k);
    send(vecs[k].mask, vecs[k].data, vecs[k].tag, vecs[k].exp_data, 1'b0);
    wait_rsp(vecs[k].exp_lat);
    ack();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [NL-1:0]    rm;
    logic [NL*IW-1:0] rd;
    logic [TW-1:0]    rt;
    logic [EW-1:0]    hold_exp;

    edge_v = '{20'h000FF, 20'h00100, 20'h7FFFF, 20'h80000, 20'hFFFFF, 20'h00000};

    vecs[0] = '{4'hF, {20'h000FF, 20'h80000, 20'h00100, 20'h00042}, 8'h5A, 32'hFF00FF42, 5};
    vecs[1] = '{4'h5, {20'h00010, 20'hFFFFF, 20'h12345, 20'h7FFFF}, 8'hA5, 32'h000000FF, 3};
    vecs[2] = '{4'h0, {20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF}, 8'h3C, 32'h00000000, 1};
    vecs[3] = '{4'hF, {20'h80000, 20'h7FFFF, 20'h00100, 20'h000FF}, 8'h11, 32'h00FFFFFF, 5};
    vecs[4] = '{4'hF, {20'h000FE, 20'h00001, 20'h00000, 20'hFFFFF}, 8'h22, 32'hFE010000, 5};
    vecs[5] = '{4'h8, {20'h00080, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF}, 8'h44, 32'h80000000, 2};
    vecs[6] = '{4'h6, {20'h00044, 20'h80001, 20'h00022, 20'h00011}, 8'h66, 32'h00002200, 3};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_mask  = '0;
    req_data  = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data",  64'(rsp_data),  64'd0);
    chk("reset_rsp_mask",  64'(rsp_mask),  64'd0);
    chk("reset_rsp_tag",   64'(rsp_tag),   64'd0);
`ifdef TEX_SAT_STATS_EN
    chk("reset_ovf", 64'(sat_ovf_count), 64'd0);
    chk("reset_unf", 64'(sat_unf_count), 64'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("release_req_ready", 64'(req_ready), 64'd1);

    // First scenario twice, then the counters have fixed values
    run_vec(0);
    run_vec(0);
`ifdef TEX_SAT_STATS_EN
    chk("ovf_after_two", 64'(sat_ovf_count), 64'd4);
    chk("unf_after_two", 64'(sat_unf_count), 64'd2);
`endif

    // Table vectors
    for (int k = 0; k < 7; k++) run_vec(k);

    // Long backpressure with a competing request held on the input
    send(vecs[0].mask, vecs[0].data, vecs[0].tag, vecs[0].exp_data, 1'b1);
    req_mask = vecs[4].mask;
    req_data = vecs[4].data;
    req_tag  = 8'hC3;
    wait_rsp(5);
    hold_exp = last_exp;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_payload", 64'({rsp_tag, rsp_mask, rsp_data}), 64'(hold_exp));
    end
    ack();
    send(vecs[4].mask, vecs[4].data, 8'hC3, vecs[4].exp_data, 1'b0);
    wait_rsp(5);
    ack();

    // Reset two cycles into RUN
    send(vecs[0].mask, vecs[0].data, vecs[0].tag, vecs[0].exp_data, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrun_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrun_req_ready", 64'(req_ready), 64'd0);
    chk("midrun_rsp_data",  64'(rsp_data),  64'd0);
    chk("midrun_rsp_tag",   64'(rsp_tag),   64'd0);
    chk("midrun_rsp_mask",  64'(rsp_mask),  64'd0);
    exp_q.delete();
    model_ovf = 0;
    model_unf = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_release_ready", 64'(req_ready), 64'd1);
    chk("midrun_release_valid", 64'(rsp_valid), 64'd0);
    run_vec(3);

    // Randomized requests against the reference model
    for (int r = 0; r < 40; r++) begin
      rm = NL'($urandom);
      for (int i = 0; i < NL; i++) rd[i*IW +: IW] = rand_lane();
      rt = TW'($urandom);
      send(rm, rd, rt, model_data(rm, rd), 1'b0);
      wait_rsp(1 + $countones(rm));
      hold_exp = last_exp;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rand_hold_payload", 64'({rsp_tag, rsp_mask, rsp_data}), 64'(hold_exp));
      end
      ack();
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
